// File: rtl/code_entry_ctrl_if.sv
// Bundle between the keypad/comparator side and the passcode sequencer.
// Parameter: DIGITS - BCD digits per code (code width = 4*DIGITS).
// Signals:
//   key_in      encoder output, [4]=press valid, [3:0]=BCD digit
//   enroll      next entry is an enrollment
//   clear       synchronous abort / relock, level
//   eq          comparator result for code_out vs stored_code
//   code_out    digits entered so far, newest in [3:0]
//   stored_code enrolled code
//   digit_cnt   digits captured in the current entry
//   unlocked    high while open
//   fail        1-cycle pulse on a failed verify
//   locked_out  high while in lockout
//   enrolled    1-cycle pulse when stored_code is written
// Modports: master = keypad/comparator side, slave = sequencer.
interface code_entry_ctrl_if #(
  parameter int unsigned DIGITS = 8
);
  logic [4:0]          key_in;
  logic                enroll;
  logic                clear;
  logic                eq;
  logic [4*DIGITS-1:0] code_out;
  logic [4*DIGITS-1:0] stored_code;
  logic [3:0]          digit_cnt;
  logic                unlocked;
  logic                fail;
  logic                locked_out;
  logic                enrolled;

  modport master (
    output key_in, enroll, clear, eq,
    input  code_out, stored_code, digit_cnt, unlocked, fail, locked_out, enrolled
  );

  modport slave (
    input  key_in, enroll, clear, eq,
    output code_out, stored_code, digit_cnt, unlocked, fail, locked_out, enrolled
  );
endinterface

// File: rtl/code_entry_ctrl.sv
// Keypad passcode sequencer: edge-detects encoder presses, assembles BCD digits into code_out,
// holds the enrolled code and runs the lock FSM (open / fail / lockout after MAX_TRIES misses).
// Ports:
//   clk  - clock, rising edge
//   rst  - asynchronous active-low reset
//   bus  - code_entry_ctrl_if.slave (key_in, enroll, clear, eq in; code/status out)
// Optional feature: define CODE_TIMEOUT_EN to abort an entry after TIMEOUT_CYCLES cycles
// without a press (no fail, not counted as a try). Undefined: entry waits indefinitely.
module code_entry_ctrl #(
  parameter int unsigned         DIGITS         = 8,
  parameter int unsigned         MAX_TRIES      = 3,
  parameter int unsigned         LOCKOUT_CYCLES = 1000,
  parameter int unsigned         TIMEOUT_CYCLES = 5000,
  parameter logic [4*DIGITS-1:0] DEFAULT_CODE   = '0
) (
  input logic              clk,
  input logic              rst,
  code_entry_ctrl_if.slave bus
);
  localparam int unsigned W      = 4 * DIGITS;
  localparam int unsigned TRY_W  = $clog2(MAX_TRIES + 1);
  localparam int unsigned LOCK_W = $clog2(LOCKOUT_CYCLES + 1);

  typedef enum logic [2:0] {StIdle, StEntry, StCheck, StOpen, StLockout} state_e;

  state_e             state_q, state_d;
  logic               valid_q;
  logic [W-1:0]       code_q, code_d;
  logic [3:0]         cnt_q, cnt_d;
  logic [W-1:0]       stored_q, stored_d;
  logic [TRY_W-1:0]   tries_q, tries_d;
  logic               first_enroll_q, first_enroll_d;
  logic               mode_enroll_q, mode_enroll_d;
  logic               fail_q, fail_d;
  logic               enrolled_q, enrolled_d;
  logic [LOCK_W-1:0]  lock_cnt_q, lock_cnt_d;

  logic press, accept, last_digit, try_last, lock_done, timeout, capture, clr_entry, verdict;

  assign press      = bus.key_in[4] & ~valid_q;
  assign accept     = press & (bus.key_in[3:0] <= 4'd9);
  assign last_digit = (cnt_q == 4'(DIGITS - 1));
  assign try_last   = (tries_q >= TRY_W'(MAX_TRIES - 1));
  assign lock_done  = (lock_cnt_q == LOCK_W'(LOCKOUT_CYCLES - 1));

`ifdef CODE_TIMEOUT_EN
  localparam int unsigned TO_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [TO_W-1:0] idle_cnt_q, idle_cnt_d;

  // Restarts on every press (valid or not) and only runs while an entry is open.
  assign idle_cnt_d = (state_q == StEntry && !press) ? idle_cnt_q + 1'b1 : '0;
  assign timeout    = (state_q == StEntry) && !press &&
                      (idle_cnt_q == TO_W'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) idle_cnt_q <= '0;
    else      idle_cnt_q <= idle_cnt_d;
  end
`else
  assign timeout = 1'b0;
`endif

  // State register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= StIdle;
    else      state_q <= state_d;
  end

  // Next-state logic; clear always beats a simultaneous press (except in lockout).
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle: begin
        if (!bus.clear && accept) state_d = last_digit ? StCheck : StEntry;
      end
      StEntry: begin
        if (bus.clear)                 state_d = StIdle;
        else if (accept && last_digit) state_d = StCheck;
        else if (timeout)              state_d = StIdle;
      end
      StCheck: begin
        if (bus.clear || mode_enroll_q) state_d = StIdle;
        else if (bus.eq)                state_d = StOpen;
        else if (try_last)              state_d = StLockout;
        else                            state_d = StIdle;
      end
      StOpen: begin
        if (bus.clear)                   state_d = StIdle;
        else if (accept && bus.enroll)   state_d = last_digit ? StCheck : StEntry;
      end
      StLockout: begin
        if (lock_done) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  // Datapath next-state. CHECK doubles as the commit cycle for enrollments.
  always_comb begin
    capture = !bus.clear && accept &&
              (state_q == StIdle || state_q == StEntry || (state_q == StOpen && bus.enroll));
    clr_entry = (state_q == StCheck) || (state_q == StEntry && (bus.clear || timeout));
    verdict   = (state_q == StCheck) && !bus.clear && !mode_enroll_q;

    code_d = code_q;
    cnt_d  = cnt_q;
    if (clr_entry) begin
      code_d = '0;
      cnt_d  = '0;
    end else if (capture) begin
      code_d = {code_q[W-5:0], bus.key_in[3:0]};
      cnt_d  = cnt_q + 4'd1;
    end

    // Mode is latched on the first press of an entry only.
    mode_enroll_d = mode_enroll_q;
    if (capture && state_q != StEntry) begin
      mode_enroll_d = (state_q == StOpen) ? 1'b1 : (bus.enroll & first_enroll_q);
    end

    enrolled_d     = (state_q == StCheck) && !bus.clear && mode_enroll_q;
    stored_d       = enrolled_d ? code_q : stored_q;
    first_enroll_d = enrolled_d ? 1'b0 : first_enroll_q;
    fail_d         = verdict && !bus.eq;

    tries_d = tries_q;
    if (verdict) begin
      if (bus.eq)        tries_d = '0;
      else if (try_last) tries_d = TRY_W'(MAX_TRIES);
      else               tries_d = tries_q + 1'b1;
    end else if (state_q == StLockout && lock_done) begin
      tries_d = '0;
    end

    lock_cnt_d = (state_q == StLockout) ? lock_cnt_q + 1'b1 : '0;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      valid_q        <= 1'b0;
      code_q         <= '0;
      cnt_q          <= '0;
      stored_q       <= DEFAULT_CODE;
      tries_q        <= '0;
      first_enroll_q <= 1'b1;
      mode_enroll_q  <= 1'b0;
      fail_q         <= 1'b0;
      enrolled_q     <= 1'b0;
      lock_cnt_q     <= '0;
    end else begin
      valid_q        <= bus.key_in[4];
      code_q         <= code_d;
      cnt_q          <= cnt_d;
      stored_q       <= stored_d;
      tries_q        <= tries_d;
      first_enroll_q <= first_enroll_d;
      mode_enroll_q  <= mode_enroll_d;
      fail_q         <= fail_d;
      enrolled_q     <= enrolled_d;
      lock_cnt_q     <= lock_cnt_d;
    end
  end

  // Outputs
  always_comb begin
    bus.code_out    = code_q;
    bus.stored_code = stored_q;
    bus.digit_cnt   = cnt_q;
    bus.unlocked    = (state_q == StOpen);
    bus.locked_out  = (state_q == StLockout);
    bus.fail        = fail_q;
    bus.enrolled    = enrolled_q;
  end
endmodule

// File: tb/tb_code_entry_ctrl.sv
// Directed bench for code_entry_ctrl with an equality comparator closing the eq loop.
module tb_code_entry_ctrl;
  logic clk = 1'b0;
  logic rst = 1'b0;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  code_entry_ctrl_if #(.DIGITS(8)) bus ();

  assign bus.eq = (bus.code_out == bus.stored_code);

  code_entry_ctrl #(
    .DIGITS(8), .MAX_TRIES(3), .LOCKOUT_CYCLES(16), .TIMEOUT_CYCLES(32), .DEFAULT_CODE(32'h0)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic key(input logic [3:0] d);
    bus.key_in = {1'b1, d};
    tick();
    bus.key_in = '0;
    tick();
  endtask

  // Presses 8 digits (MSB nibble first); samples code_out/unlocked in the cycle after the
  // last press edge. Returns 2 clk after the last press.
  task automatic enter8(input logic [31:0] code, input logic drop_enroll,
                        output logic [31:0] at_check, output logic unl_at_check);
    logic [3:0] d;
    at_check = '0;
    unl_at_check = 1'b0;
    for (int i = 0; i < 8; i++) begin
      d = code[31-4*i -: 4];
      bus.key_in = {1'b1, d};
      tick();
      if (i == 7) begin
        at_check = bus.code_out;
        unl_at_check = bus.unlocked;
      end
      if (i == 0 && drop_enroll) bus.enroll = 1'b0;
      bus.key_in = '0;
      tick();
    end
  endtask

  task automatic test_reset();
    bus.key_in = '0; bus.enroll = 1'b0; bus.clear = 1'b0;
    rst = 1'b0;
    tick(); tick();
    checks++;
    if (bus.code_out !== 32'h0 || bus.digit_cnt !== 4'd0 || bus.stored_code !== 32'h0) begin
      errors++;
      $display("FAIL reset_data code=%h cnt=%0d stored=%h required 0/0/0",
               bus.code_out, bus.digit_cnt, bus.stored_code);
    end
    checks++;
    if ({bus.unlocked, bus.fail, bus.locked_out, bus.enrolled} !== 4'b0000) begin
      errors++;
      $display("FAIL reset_flags got %b required 0000",
               {bus.unlocked, bus.fail, bus.locked_out, bus.enrolled});
    end
    rst = 1'b1;
    tick();
  endtask

  task automatic test_enroll();
    logic [31:0] c;
    logic u;
    bus.enroll = 1'b1;
    enter8(32'h12345678, 1'b0, c, u);
    bus.enroll = 1'b0;
    checks++;
    if (bus.stored_code !== 32'h12345678) begin
      errors++; $display("FAIL enroll_store got %h required 12345678", bus.stored_code);
    end
    checks++;
    if (bus.enrolled !== 1'b1 || bus.unlocked !== 1'b0) begin
      errors++; $display("FAIL enroll_pulse enrolled=%b unlocked=%b required 1/0",
                         bus.enrolled, bus.unlocked);
    end
    checks++;
    if (bus.code_out !== 32'h0 || bus.digit_cnt !== 4'd0) begin
      errors++; $display("FAIL enroll_clear code=%h cnt=%0d required 0/0",
                         bus.code_out, bus.digit_cnt);
    end
    tick();
    checks++;
    if (bus.enrolled !== 1'b0) begin
      errors++; $display("FAIL enroll_one_cycle got %b required 0", bus.enrolled);
    end
  endtask

  task automatic test_verify_open();
    logic [31:0] c;
    logic u;
    enter8(32'h12345678, 1'b0, c, u);
    checks++;
    if (c !== 32'h12345678 || u !== 1'b0) begin
      errors++; $display("FAIL verify_check code=%h unlocked=%b required 12345678/0", c, u);
    end
    checks++;
    if (bus.unlocked !== 1'b1 || bus.fail !== 1'b0) begin
      errors++; $display("FAIL verify_open unlocked=%b fail=%b required 1/0",
                         bus.unlocked, bus.fail);
    end
    bus.clear = 1'b1;
    tick();
    bus.clear = 1'b0;
    checks++;
    if (bus.unlocked !== 1'b0) begin
      errors++; $display("FAIL clear_relock got %b required 0", bus.unlocked);
    end
  endtask

  task automatic test_lockout();
    logic [31:0] c;
    logic u;
    int n;
    for (int t = 0; t < 3; t++) begin
      enter8(32'h99999999, 1'b0, c, u);
      checks++;
      if (bus.fail !== 1'b1 || bus.unlocked !== 1'b0) begin
        errors++; $display("FAIL lock_try%0d fail=%b unlocked=%b required 1/0",
                           t, bus.fail, bus.unlocked);
      end
      checks++;
      if (bus.locked_out !== (t == 2)) begin
        errors++; $display("FAIL lock_state%0d got %b required %b", t, bus.locked_out, t == 2);
      end
    end
    n = 0;
    while (bus.locked_out === 1'b1 && n < 40) begin
      n++;
      bus.key_in = {n[0], 4'd9};
      tick();
    end
    bus.key_in = '0;
    checks++;
    if (n !== 16) begin
      errors++; $display("FAIL lock_duration got %0d required 16", n);
    end
    checks++;
    if (bus.digit_cnt !== 4'd0 || bus.code_out !== 32'h0) begin
      errors++; $display("FAIL lock_ignore cnt=%0d code=%h required 0/0",
                         bus.digit_cnt, bus.code_out);
    end
    tick();
    enter8(32'h12345678, 1'b0, c, u);
    checks++;
    if (bus.unlocked !== 1'b1) begin
      errors++; $display("FAIL lock_then_open got %b required 1", bus.unlocked);
    end
    bus.clear = 1'b1; tick(); bus.clear = 1'b0;
  endtask

  task automatic test_held_key();
    bus.key_in = {1'b1, 4'd5};
    repeat (10) tick();
    bus.key_in = '0;
    tick();
    checks++;
    if (bus.digit_cnt !== 4'd1 || bus.code_out !== 32'h5) begin
      errors++; $display("FAIL held_key cnt=%0d code=%h required 1/00000005",
                         bus.digit_cnt, bus.code_out);
    end
    key(4'hA);
    checks++;
    if (bus.digit_cnt !== 4'd1 || bus.code_out !== 32'h5) begin
      errors++; $display("FAIL bad_digit cnt=%0d code=%h required 1/00000005",
                         bus.digit_cnt, bus.code_out);
    end
    bus.clear = 1'b1;
    bus.key_in = {1'b1, 4'd7};
    tick();
    bus.clear = 1'b0;
    bus.key_in = '0;
    tick();
    checks++;
    if (bus.digit_cnt !== 4'd0 || bus.code_out !== 32'h0 || bus.fail !== 1'b0) begin
      errors++; $display("FAIL clear_press cnt=%0d code=%h fail=%b required 0/0/0",
                         bus.digit_cnt, bus.code_out, bus.fail);
    end
  endtask

  task automatic test_enroll_rules();
    logic [31:0] c;
    logic u;
    bus.enroll = 1'b1;
    enter8(32'h11111111, 1'b0, c, u);
    bus.enroll = 1'b0;
    checks++;
    if (bus.stored_code !== 32'h12345678 || bus.enrolled !== 1'b0 || bus.fail !== 1'b1) begin
      errors++; $display("FAIL reenroll_idle stored=%h enrolled=%b fail=%b required 12345678/0/1",
                         bus.stored_code, bus.enrolled, bus.fail);
    end
    enter8(32'h12345678, 1'b0, c, u);
    key(4'd3);
    checks++;
    if (bus.unlocked !== 1'b1 || bus.digit_cnt !== 4'd0) begin
      errors++; $display("FAIL open_press_ignored unlocked=%b cnt=%0d required 1/0",
                         bus.unlocked, bus.digit_cnt);
    end
    bus.enroll = 1'b1;
    enter8(32'h87654321, 1'b1, c, u);
    checks++;
    if (bus.stored_code !== 32'h87654321 || bus.enrolled !== 1'b1 || bus.unlocked !== 1'b0) begin
      errors++; $display("FAIL open_enroll stored=%h enrolled=%b unlocked=%b required 87654321/1/0",
                         bus.stored_code, bus.enrolled, bus.unlocked);
    end
    enter8(32'h87654321, 1'b0, c, u);
    checks++;
    if (bus.unlocked !== 1'b1) begin
      errors++; $display("FAIL new_code_open got %b required 1", bus.unlocked);
    end
    bus.clear = 1'b1; tick(); bus.clear = 1'b0;
  endtask

  task automatic test_timeout();
`ifdef CODE_TIMEOUT_EN
    key(4'd1); key(4'd2); key(4'd3);
    repeat (30) tick();
    checks++;
    if (bus.digit_cnt !== 4'd3) begin
      errors++; $display("FAIL timeout_early got %0d required 3", bus.digit_cnt);
    end
    tick();
    checks++;
    if (bus.digit_cnt !== 4'd0 || bus.code_out !== 32'h0 || bus.fail !== 1'b0) begin
      errors++; $display("FAIL timeout_expire cnt=%0d code=%h fail=%b required 0/0/0",
                         bus.digit_cnt, bus.code_out, bus.fail);
    end
`endif
  endtask

  task automatic test_reset_mid_entry();
    key(4'd1); key(4'd2); key(4'd3);
    checks++;
    if (bus.digit_cnt !== 4'd3 || bus.code_out !== 32'h123) begin
      errors++; $display("FAIL partial cnt=%0d code=%h required 3/00000123",
                         bus.digit_cnt, bus.code_out);
    end
    #2 rst = 1'b0;
    #1;
    checks++;
    if (bus.digit_cnt !== 4'd0 || bus.code_out !== 32'h0 || bus.stored_code !== 32'h0 ||
        {bus.unlocked, bus.fail, bus.locked_out, bus.enrolled} !== 4'b0000) begin
      errors++; $display("FAIL reset_mid cnt=%0d code=%h stored=%h required 0/0/0",
                         bus.digit_cnt, bus.code_out, bus.stored_code);
    end
    tick();
    rst = 1'b1;
    tick();
  endtask

  initial begin
    test_reset();
    test_enroll();
    test_verify_open();
    test_lockout();
    test_held_key();
    test_enroll_rules();
    test_timeout();
    test_reset_mid_entry();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
